// File: rtl/sequenciador_quadros.sv
// Frame sequencer: periodic frame timer, byte address walk over one frame,
// one-cycle image read latency absorption, valid/ready byte hand-off to the
// display transmitter and per-state animation frame indexing.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ESPERA   | idle between frames, waiting for a pending tick + enable
// BUSCA    | byte address presented to the image controller
// CARREGA  | image data valid, captured into tx_data
// ENVIA    | tx_valid held until the transmitter accepts the byte
// FIM      | frame complete: done pulse, animation index update
module sequenciador_quadros #(
  parameter int FRAME_BYTES  = 1024,
  parameter int FRAME_PERIOD = 2700000,
  parameter int ANIM_DIVIDER = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] estado,
  input  logic [7:0] pixel_data,
  output logic [9:0] byte_counter,
  output logic [3:0] estado_frame,
  output logic [2:0] anim_index,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_busy,
  output logic       frame_done
);

  localparam int TW = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
  localparam int DW = $clog2(ANIM_DIVIDER + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_PERIOD - 1);
  localparam logic [9:0]    BYTE_LAST  = 10'(FRAME_BYTES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(ANIM_DIVIDER);

  localparam logic [2:0] ESPERA  = 3'd0;
  localparam logic [2:0] BUSCA   = 3'd1;
  localparam logic [2:0] CARREGA = 3'd2;
  localparam logic [2:0] ENVIA   = 3'd3;
  localparam logic [2:0] FIM     = 3'd4;

  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic [2:0]    state_q, state_d;
  logic [9:0]    byte_counter_q, byte_counter_d;
  logic [3:0]    estado_frame_q, estado_frame_d;
  logic [2:0]    anim_q, anim_d;
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tick;
  logic          start;
  logic [2:0]    anim_last;
  logic [DW-1:0] div_inc;

  // Highest animation index for the latched state; unknown codes use 6 frames.
  always_comb begin
    case (estado_frame_q)
      4'b0001: anim_last = 3'd3;
      4'b0010: anim_last = 3'd4;
      4'b0100: anim_last = 3'd6;
      4'b1000: anim_last = 3'd7;
      default: anim_last = 3'd5;
    endcase
  end

  // Next-state logic: frame timer, pending flag, sequencing FSM and animation.
  always_comb begin
    timer_d        = timer_q;
    state_d        = state_q;
    byte_counter_d = byte_counter_q;
    estado_frame_d = estado_frame_q;
    anim_d         = anim_q;
    div_d          = div_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    start          = 1'b0;
    div_inc        = div_q + DW'(1);

    tick    = (timer_q == TIMER_LAST);
    timer_d = tick ? '0 : timer_q + TW'(1);

    case (state_q)
      ESPERA: begin
        if (pending_q && enable) begin
          start          = 1'b1;
          byte_counter_d = '0;
          estado_frame_d = estado;
          busy_d         = 1'b1;
          state_d        = BUSCA;
          // A new pet state restarts its animation from the first frame.
          if (estado != estado_frame_q) begin
            anim_d = '0;
            div_d  = '0;
          end
        end
      end
      BUSCA: begin
        state_d = CARREGA;
      end
      CARREGA: begin
        tx_data_d  = pixel_data;
        tx_valid_d = 1'b1;
        state_d    = ENVIA;
      end
      ENVIA: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (byte_counter_q == BYTE_LAST) begin
            state_d = FIM;
          end else begin
            byte_counter_d = byte_counter_q + 10'd1;
            state_d        = BUSCA;
          end
        end
      end
      FIM: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ESPERA;
        if (div_inc == DIV_LAST) begin
          div_d  = '0;
          anim_d = (anim_q == anim_last) ? 3'd0 : anim_q + 3'd1;
        end else begin
          div_d = div_inc;
        end
      end
      default: begin
        state_d = ESPERA;
      end
    endcase

    // A tick on the same edge a frame starts queues the following frame.
    pending_d = (pending_q & ~start) | tick;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q        <= '0;
      pending_q      <= 1'b0;
      state_q        <= ESPERA;
      byte_counter_q <= '0;
      estado_frame_q <= '0;
      anim_q         <= '0;
      div_q          <= '0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      timer_q        <= timer_d;
      pending_q      <= pending_d;
      state_q        <= state_d;
      byte_counter_q <= byte_counter_d;
      estado_frame_q <= estado_frame_d;
      anim_q         <= anim_d;
      div_q          <= div_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign byte_counter = byte_counter_q;
  assign estado_frame = estado_frame_q;
  assign anim_index   = anim_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign frame_busy   = busy_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_sequenciador_quadros.sv
// Bench for sequenciador_quadros: behavioural frame model compared every
// cycle, randomized transmitter back-pressure, directed frame scenarios.
module tb_sequenciador_quadros;

  localparam int FB = 1024;
  localparam int FP = 100;
  localparam int AD = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] estado = 4'b0000;
  logic [7:0] pixel_data = 8'h00;
  logic       tx_ready = 1'b1;
  logic [9:0] byte_counter;
  logic [3:0] estado_frame;
  logic [2:0] anim_index;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       frame_busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sequenciador_quadros #(
    .FRAME_BYTES (FB),
    .FRAME_PERIOD(FP),
    .ANIM_DIVIDER(AD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .estado      (estado),
    .pixel_data  (pixel_data),
    .byte_counter(byte_counter),
    .estado_frame(estado_frame),
    .anim_index  (anim_index),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done)
  );

  // Image content as a function of address, state and animation frame.
  function automatic logic [7:0] pix(input int b, input int s, input int a);
    return 8'((b * 7 + s * 19 + a * 37 + 90) & 255);
  endfunction

  function automatic int anim_size(input logic [3:0] s);
    case (s)
      4'b0001: return 4;
      4'b0010: return 5;
      4'b0100: return 7;
      4'b1000: return 8;
      default: return 6;
    endcase
  endfunction

  // Image controller with one-cycle registered read latency.
  always @(posedge clk)
    pixel_data <= pix(int'(byte_counter), int'(estado_frame), int'(anim_index));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_timer, m_byte, m_lat, m_div, m_anim;
  bit         m_pend, m_busy, m_txv, m_fin, m_done, m_live;
  logic [3:0] m_sf;
  logic [7:0] m_txd;

  task automatic model_step();
    bit t, st;
    if (rst) begin
      m_timer = 0; m_byte = 0; m_lat = 0; m_div = 0; m_anim = 0;
      m_pend = 0; m_busy = 0; m_txv = 0; m_fin = 0; m_done = 0;
      m_sf = 4'b0000; m_txd = 8'h00; m_live = 1;
    end else begin
      t = (m_timer == FP - 1);
      m_timer = t ? 0 : m_timer + 1;
      st = 0;
      m_done = 0;
      if (!m_busy) begin
        if (m_pend && enable) begin
          st = 1; m_busy = 1; m_byte = 0; m_lat = 2;
          if (estado != m_sf) begin m_anim = 0; m_div = 0; end
          m_sf = estado;
        end
      end else if (m_fin) begin
        m_fin = 0; m_busy = 0; m_done = 1;
        m_div = m_div + 1;
        if (m_div == AD) begin
          m_div = 0;
          m_anim = (m_anim + 1) % anim_size(m_sf);
        end
      end else if (m_txv) begin
        if (tx_ready) begin
          m_txv = 0;
          if (m_byte == FB - 1) m_fin = 1;
          else begin m_byte = m_byte + 1; m_lat = 2; end
        end
      end else begin
        if (m_lat == 1) begin
          m_txv = 1;
          m_txd = pix(m_byte, int'(m_sf), m_anim);
        end
        m_lat = m_lat - 1;
      end
      m_pend = (m_pend && !st) || t;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_live) begin
      chk("byte_counter", byte_counter, m_byte);
      chk("estado_frame", estado_frame, m_sf);
      chk("anim_index", anim_index, m_anim);
      chk("tx_valid", tx_valid, m_txv);
      chk("tx_data", tx_data, m_txd);
      chk("frame_busy", frame_busy, m_busy);
      chk("frame_done", frame_done, m_done);
    end
  end

  // ---------------- stimulus ----------------
  int cyc = 0;
  int stall = 0;
  bit rand_mode = 0;
  bit busy_prev = 0;
  int rise_cnt = 0, rise_cyc = 0, done_cyc = 0;
  logic [3:0] rise_sf;
  logic [2:0] rise_anim;

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic timeout(input string name);
    errors++;
    $display("FAIL %s: timeout waiting at cycle %0d", name, cyc);
    finish_sim();
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (stall > 0) begin
      tx_ready = 1'b0;
      stall--;
    end else begin
      tx_ready = rand_mode ? ($urandom_range(0, 9) != 0) : 1'b1;
    end
    if (frame_busy && !busy_prev) begin
      rise_cnt++;
      rise_cyc  = cyc;
      rise_sf   = estado_frame;
      rise_anim = anim_index;
    end
    busy_prev = frame_busy;
    if (frame_done) done_cyc = cyc;
  endtask

  initial begin
    logic [3:0] exp_sf [16];
    int         exp_an [16];
    int         start_cyc, prev_done, v17, last17, first18, n;
    bit         stalled, mid_set, saw_busy, seen;

    for (int f = 0; f < 16; f++) begin
      exp_sf[f] = (f == 0) ? 4'b0000 : (f == 1) ? 4'b0100 : (f < 7) ? 4'b0001 : 4'b1000;
      exp_an[f] = (f < 2) ? 0 : (f < 7) ? (f - 2) % 4 : (f - 7) % 8;
    end

    rst = 1'b1; enable = 1'b1; estado = 4'b0000; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_byte_counter", byte_counter, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_frame_busy", frame_busy, 0);
    rst = 1'b0;
    cyc = 0;

    n = 0;
    while (!tx_valid) begin
      step();
      if (++n > 1000) timeout("first_valid");
    end
    chk("first_valid_cycle", cyc, FP + 3);
    chk("first_tx_data", tx_data, 8'h5A);

    stalled = 0; mid_set = 0; v17 = 0; last17 = 0; first18 = 0; prev_done = 0;
    for (int f = 0; f < 16; f++) begin
      n = 0;
      while (rise_cnt <= f) begin
        step();
        if (++n > 20000) timeout("frame_start");
      end
      start_cyc = rise_cyc;
      chk("start_estado_frame", rise_sf, exp_sf[f]);
      chk("start_anim_index", rise_anim, exp_an[f]);
      if (f > 0) chk("frame_gap", start_cyc - prev_done, 1);
      if (f == 1) estado = 4'b0001;
      if (f == 6) estado = 4'b1000;
      rand_mode = (f > 0);

      n = 0;
      seen = 0;
      while (!seen) begin
        step();
        if (frame_done && cyc > start_cyc) seen = 1;
        if (f == 0) begin
          if (tx_valid && byte_counter == 10'd17) begin
            if (!stalled) begin tx_ready = 1'b0; stall = 4; stalled = 1; end
            v17++;
            last17 = cyc;
          end
          if (tx_valid && byte_counter == 10'd18 && first18 == 0) first18 = cyc;
          if (byte_counter == 10'd500 && !mid_set) begin
            estado = 4'b0100;
            mid_set = 1;
          end
          if (mid_set && frame_busy) chk("mid_frame_estado_frame", estado_frame, 4'b0000);
        end
        if (++n > 20000) timeout("frame_done");
      end
      prev_done = done_cyc;
      if (f == 0) begin
        chk("stall_hold_cycles", v17, 6);
        chk("byte18_after_accept", first18 - last17, 3);
        chk("frame0_length", done_cyc - start_cyc, 3 * FB + 1 + 5);
        chk("frame0_end_estado", estado_frame, 4'b0000);
      end
    end

    n = 0;
    while (rise_cnt <= 16) begin
      step();
      if (++n > 20000) timeout("frame16_start");
    end
    n = 0;
    while (!(tx_valid && byte_counter == 10'd300)) begin
      step();
      if (++n > 20000) timeout("byte300");
    end
    rst = 1'b1;
    enable = 1'b0;
    step();
    chk("mid_rst_byte_counter", byte_counter, 0);
    chk("mid_rst_estado_frame", estado_frame, 0);
    chk("mid_rst_anim_index", anim_index, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_frame_busy", frame_busy, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    rst = 1'b0;
    saw_busy = 0;
    for (int i = 0; i < 350; i++) begin
      step();
      if (frame_busy) saw_busy = 1;
    end
    chk("disabled_no_frame", saw_busy, 0);
    enable = 1'b1;
    step();
    chk("pending_kept_start", frame_busy, 1);
    repeat (20) step();
    finish_sim();
  end

endmodule
